// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one simple_bus memory port between NUM_REQ masters.
// Optional rdy timeout: define SIMPLE_BUS_ARB_TIMEOUT_EN (bus_err is tied 0 otherwise).
module simple_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      m_req,
  output logic [NUM_REQ-1:0]      m_gnt,
  input  logic [NUM_REQ-1:0]      m_start,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
  input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
  input  logic [NUM_REQ*2-1:0]    m_mode,
  output logic [NUM_REQ-1:0]      m_rdy,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    bus_start,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  output logic [1:0]              bus_mode,
  input  logic                    bus_rdy,
  input  logic [DATA_W-1:0]       bus_rdata,
  output logic                    bus_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_RELEASE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rdy_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               bus_start_q;
  logic [ADDR_W-1:0]  bus_addr_q;
  logic [DATA_W-1:0]  bus_wdata_q;
  logic [1:0]         bus_mode_q;

  logic [IDX_W-1:0]   win_d;
  logic               win_vld;
  int unsigned        scan_idx;

  // First requester found scanning upward from ptr with wrap.
  always_comb begin
    win_d    = '0;
    win_vld  = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= unsigned'(NUM_REQ)) scan_idx = scan_idx - unsigned'(NUM_REQ);
      if (!win_vld && m_req[IDX_W'(scan_idx)]) begin
        win_vld = 1'b1;
        win_d   = IDX_W'(scan_idx);
      end
    end
  end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  logic [7:0] timer_q;
  logic       bus_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      rdy_q       <= '0;
      rdata_q     <= '0;
      bus_start_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mode_q  <= '0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
      timer_q     <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            win_q   <= win_d;
            gnt_q   <= NUM_REQ'(1) << win_d;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Start takes priority over a simultaneous req drop.
          if (m_start[win_q]) begin
            bus_addr_q  <= m_addr[win_q*ADDR_W +: ADDR_W];
            bus_wdata_q <= m_wdata[win_q*DATA_W +: DATA_W];
            bus_mode_q  <= m_mode[win_q*2 +: 2];
            bus_start_q <= 1'b1;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            timer_q     <= '0;
`endif
            state_q     <= S_XFER;
          end else if (!m_req[win_q]) begin
            state_q <= S_RELEASE;
          end
        end
        S_XFER: begin
          bus_start_q <= 1'b0;
          if (bus_rdy) begin
            rdata_q <= bus_rdata;
            rdy_q   <= gnt_q;
            state_q <= S_RELEASE;
          end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
          else if (timer_q == 8'(TIMEOUT)) begin
            bus_err_q <= 1'b1;
            rdy_q     <= gnt_q;
            state_q   <= S_RELEASE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
`endif
        end
        S_RELEASE: begin
          gnt_q   <= '0;
          rdy_q   <= '0;
          ptr_q   <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
          bus_err_q <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_gnt     = gnt_q;
  assign m_rdy     = rdy_q;
  assign m_rdata   = rdata_q;
  assign bus_start = bus_start_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_mode  = bus_mode_q;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule
